// File: rtl/mem_byte_bridge.sv
// rtl/mem_byte_bridge.sv - serialises byte/half/word core loads and stores onto a byte-wide req/ack memory port.
// Load data is returned little-endian assembled and sign/zero-extended; misalignment and ack timeout report rsp_err.
module mem_byte_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        load_ext_sel,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              write_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [2:0]        ext_q;
  logic              err_q;
  logic [15:0]       tcnt_q;

  logic              align_ok;
  logic [1:0]        last_nx;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] sel);
    case (sel)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd3:    extend = {24'h0, d[7:0]};
      3'd4:    extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    align_ok = 1'b0;
    last_nx  = 2'd3;
    case (req_size)
      2'd0: begin align_ok = 1'b1;                  last_nx = 2'd0; end
      2'd1: begin align_ok = ~req_addr[0];          last_nx = 2'd1; end
      2'd2: begin align_ok = (req_addr[1:0] == 2'b00); last_nx = 2'd3; end
      default: begin align_ok = 1'b0;               last_nx = 2'd3; end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = align_ok ? XFER : DONE;
      XFER: begin
        if (mem_ack) begin
          if (idx_q == last_q) state_nx = DONE;
        end else if (tcnt_q == TMAX) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      write_q <= 1'b0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      base_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ext_q   <= 3'd0;
      err_q   <= 1'b0;
      tcnt_q  <= 16'h0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          write_q <= req_write;
          base_q  <= req_addr;
          wdata_q <= req_wdata;
          ext_q   <= load_ext_sel;
          last_q  <= last_nx;
          idx_q   <= 2'd0;
          tcnt_q  <= 16'h0;
          rdata_q <= 32'h0;
          err_q   <= ~align_ok;
        end
        XFER: begin
          // Wait counter is per byte: every ack restarts the timeout window.
          if (mem_ack) begin
            if (!write_q) rdata_q[{idx_q, 3'b000} +: 8] <= mem_rdata;
            idx_q  <= idx_q + 2'd1;
            tcnt_q <= 16'h0;
          end else if (tcnt_q == TMAX) begin
            err_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory fields are decoded from registered state so reset clears them at once.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    mem_req   = (state == XFER);
    mem_we    = mem_req && write_q;
    mem_addr  = mem_req ? (base_q + ADDR_W'(idx_q)) : '0;
    mem_wdata = mem_req ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h0;
    rsp_valid = (state == DONE);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !write_q) ? extend(rdata_q, ext_q) : 32'h0;
  end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// tb/tb_mem_byte_bridge.sv - scoreboard bench for mem_byte_bridge with a byte memory model.
module tb_mem_byte_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  load_ext_sel = 3'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  mem_byte_bridge #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_ext_sel(load_ext_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          nreq;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cnt = 0;

  logic [7:0]  mem [0:1023];
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'h0;
  logic [7:0]  pl_data = 8'h0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic [7:0]  hold_wdata = 8'h0;

  assign mem_ack   = ack_en && mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory slave: delayed ack, byte writes, backdoor preload and hold tracking.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    hold_pending <= ack_en && mem_req && !mem_ack;
    hold_addr <= mem_addr;
    hold_wdata <= mem_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr[9:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_cnt = 0;
    end else begin
      if (mem_req) req_cnt++;
      if (hold_pending) begin
        check("hold_req", 32'(mem_req), 32'h1);
        check("hold_addr", mem_addr, hold_addr);
        check("hold_wdata", 32'(mem_wdata), 32'(hold_wdata));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_cycle", cyc, e.cyc);
          check("mem_req_cycles", req_cnt, e.nreq);
        end
        req_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("rsp_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sel,
                        input logic [31:0] er, input logic ee, input int lat, input int nreq);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a;
    req_wdata = wd; load_ext_sel = sel;
    exp_q.push_back('{er, ee, cyc + lat, nreq});
    @(negedge clk);
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t0;
    @(negedge clk);
    preload(10'h100, 8'h78); preload(10'h101, 8'h56);
    preload(10'h102, 8'h34); preload(10'h103, 8'h12);
    preload(10'h201, 8'h80); preload(10'h202, 8'h01);
    preload(10'h203, 8'h80); preload(10'h012, 8'h5A);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 2'd2, 32'h100, 32'h0, 3'd2, 32'h12345678, 1'b0, 5, 4);
    do_req(1'b0, 2'd0, 32'h201, 32'h0, 3'd0, 32'hFFFFFF80, 1'b0, 2, 1);
    do_req(1'b0, 2'd0, 32'h201, 32'h0, 3'd3, 32'h00000080, 1'b0, 2, 1);
    do_req(1'b0, 2'd1, 32'h202, 32'h0, 3'd1, 32'hFFFF8001, 1'b0, 3, 2);
    do_req(1'b0, 2'd1, 32'h202, 32'h0, 3'd4, 32'h00008001, 1'b0, 3, 2);

    ack_delay = 3;
    do_req(1'b1, 2'd1, 32'h10, 32'hAABBCCDD, 3'd2, 32'h0, 1'b0, 9, 8);
    ack_delay = 0;
    check("sh_byte0", 32'(mem[16]), 32'hDD);
    check("sh_byte1", 32'(mem[17]), 32'hCC);
    check("sh_untouched", 32'(mem[18]), 32'h5A);

    do_req(1'b0, 2'd2, 32'h102, 32'h0, 3'd2, 32'h0, 1'b1, 1, 0);
    do_req(1'b0, 2'd3, 32'h100, 32'h0, 3'd2, 32'h0, 1'b1, 1, 0);
    do_req(1'b0, 2'd1, 32'h201, 32'h0, 3'd1, 32'h0, 1'b1, 1, 0);
    do_req(1'b1, 2'd2, 32'h20, 32'h11223344, 3'd2, 32'h0, 1'b0, 5, 4);
    do_req(1'b0, 2'd2, 32'h20, 32'h0, 3'd7, 32'h11223344, 1'b0, 5, 4);

    // Held req_valid during a timed-out transfer is only taken after the pulse.
    ack_en = 1'b0;
    t0 = cyc;
    exp_q.push_back('{32'h0, 1'b1, t0 + 9, 8});
    exp_q.push_back('{32'h0, 1'b1, t0 + 19, 8});
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300; load_ext_sel = 3'd2;
    repeat (5) @(negedge clk);
    check("busy_ready", 32'(req_ready), 32'h0);
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    drain();
    ack_en = 1'b1;

    // Reset while byte 2 of a word load is on the bus.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100; load_ext_sel = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_mem_req", 32'(mem_req), 32'h1);
    check("mid_mem_addr", mem_addr, 32'h102);
    rst = 1'b1;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'h0);
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 2'd2, 32'h100, 32'h0, 3'd2, 32'h12345678, 1'b0, 5, 4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
